// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x3 active-low membrane keypad, debounces whole scan frames and
//   reports the held digit as a one-hot vector for the time-entry encoder.
//   '*' and '#' are recognised only so they can be rejected.
// Ports
//   clock       system clock, rising edge
//   resetn      asynchronous active-low reset
//   rows_n[3:0] matrix rows, active-low, asynchronous to clock
//   cols_n[2:0] column strobes, active-low, exactly one low at a time
//   keypad[9:0] debounced one-hot digit (bit k = digit k held), else 0
//   key_code    binary code of the last accepted digit (held)
//   key_strobe  one-clock pulse per accepted press
module keypad_scanner #(
  parameter int unsigned SCAN_DIV = 4,
  parameter int unsigned DEBOUNCE = 3,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [3:0] rows_n,
  output logic [2:0] cols_n,
  output logic [9:0] keypad,
  output logic [3:0] key_code,
  output logic       key_strobe
);

  localparam int unsigned SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {CLS_NONE, CLS_DIGIT, CLS_OTHER} cls_e;
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_e;

  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [1:0]        col_q, col_d;
  logic [3:0]        sync1_q, sync2_q;
  logic [2:0][3:0]   snap_q, snap_d;
  logic              frame_end_q, frame_end_d;
  logic              last_slot;

  cls_e              cls_q, cls_d;
  logic [3:0]        dig_q, dig_d;
  logic              cls_vld_q;

  logic [3:0]        nlow;
  logic [1:0]        low_r, low_c;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        cand_q, cand_d;
  logic [9:0]        keypad_q, keypad_d;
  logic [3:0]        code_q, code_d;
  logic              strobe_q, strobe_d;

  // Column scan and snapshot capture
  always_comb begin
    last_slot   = (slot_q == SLOT_W'(SCAN_DIV - 1));
    slot_d      = last_slot ? '0 : slot_q + 1'b1;
    col_d       = col_q;
    snap_d      = snap_q;
    if (last_slot) begin
      snap_d[col_q] = sync2_q;
      col_d         = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
    end
    frame_end_d = last_slot && (col_q == 2'd2);
  end

  always_comb begin
    unique case (col_q)
      2'd1:    cols_n = 3'b101;
      2'd2:    cols_n = 3'b011;
      default: cols_n = 3'b110;
    endcase
  end

  // Frame classification: count low bits, remember the position of the last one
  always_comb begin
    nlow  = '0;
    low_r = '0;
    low_c = '0;
    for (int unsigned c = 0; c < 3; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        if (!snap_q[2'(c)][2'(r)]) begin
          nlow  = nlow + 4'd1;
          low_r = 2'(r);
          low_c = 2'(c);
        end
      end
    end
    cls_d = CLS_OTHER;
    dig_d = '0;
    if (nlow == 4'd0) begin
      cls_d = CLS_NONE;
    end else if (nlow == 4'd1) begin
      if (low_r != 2'd3) begin
        cls_d = CLS_DIGIT;
        dig_d = {2'b00, low_r} * 4'd3 + {2'b00, low_c} + 4'd1;
      end else if (low_c == 2'd1) begin
        cls_d = CLS_DIGIT;
        dig_d = 4'd0;
      end
    end
  end

  // Debounce FSM, acts only on the cycle a fresh classification is available
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    keypad_d = keypad_q;
    code_d   = code_q;
    strobe_d = 1'b0;
    if (cls_vld_q) begin
      unique case (state_q)
        IDLE: begin
          if (cls_q == CLS_DIGIT) begin
            cand_d = dig_q;
            if (DEBOUNCE <= 1) begin
              state_d  = PRESSED;
              cnt_d    = '0;
              keypad_d = 10'd1 << dig_q;
              code_d   = dig_q;
              strobe_d = 1'b1;
            end else begin
              state_d = PRESS_WAIT;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        PRESS_WAIT: begin
          if ((cls_q == CLS_DIGIT) && (dig_q == cand_q)) begin
            if ((cnt_q + 1'b1) == CNT_W'(DEBOUNCE)) begin
              state_d  = PRESSED;
              cnt_d    = '0;
              keypad_d = 10'd1 << cand_q;
              code_d   = cand_q;
              strobe_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        PRESSED: begin
          if (cls_q == CLS_NONE) begin
            if (DEBOUNCE <= 1) begin
              state_d  = IDLE;
              cnt_d    = '0;
              keypad_d = '0;
            end else begin
              state_d = RELEASE_WAIT;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        RELEASE_WAIT: begin
          if (cls_q == CLS_NONE) begin
            if ((cnt_q + 1'b1) == CNT_W'(DEBOUNCE)) begin
              state_d  = IDLE;
              cnt_d    = '0;
              keypad_d = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            state_d = PRESSED;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      slot_q      <= '0;
      col_q       <= '0;
      // Synchroniser and snapshot clear to the released (all-high) row level
      sync1_q     <= '1;
      sync2_q     <= '1;
      snap_q      <= '1;
      frame_end_q <= 1'b0;
      cls_q       <= CLS_NONE;
      dig_q       <= '0;
      cls_vld_q   <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      cand_q      <= '0;
      keypad_q    <= '0;
      code_q      <= '0;
      strobe_q    <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      col_q       <= col_d;
      sync1_q     <= rows_n;
      sync2_q     <= sync1_q;
      snap_q      <= snap_d;
      frame_end_q <= frame_end_d;
      if (frame_end_q) begin
        cls_q <= cls_d;
        dig_q <= dig_d;
      end
      cls_vld_q   <= frame_end_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      keypad_q    <= keypad_d;
      code_q      <= code_d;
      strobe_q    <= strobe_d;
    end
  end

  assign keypad     = keypad_q;
  assign key_code   = code_q;
  assign key_strobe = strobe_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Emulates the physical key matrix, drives directed and random key activity
//   and compares the scanner against a frame-level behavioural model.
module tb_keypad_scanner;

  localparam int S   = 4;
  localparam int DEB = 3;

  logic       clock = 1'b0;
  logic       resetn = 1'b1;
  logic [3:0] rows_n;
  logic [2:0] cols_n;
  logic [9:0] keypad;
  logic [3:0] key_code;
  logic       key_strobe;

  // Keys currently held, bit index = row*3 + col
  bit [11:0] held = '0;

  int n_chk = 0;
  int n_fail = 0;
  int strobe_cnt = 0;

  keypad_scanner #(
    .SCAN_DIV (S),
    .DEBOUNCE (DEB),
    .CNT_W    (4)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .rows_n     (rows_n),
    .cols_n     (cols_n),
    .keypad     (keypad),
    .key_code   (key_code),
    .key_strobe (key_strobe)
  );

  always #5 clock = ~clock;

  // Passive matrix: a held key shorts its row to the column being driven low
  always_comb begin
    rows_n = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (held[r*3+c] && (cols_n[c] == 1'b0)) rows_n[r] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int        n = 0;
  int        fe_edge = -1;
  bit [11:0] ring [4];
  bit [11:0] frame_acc, frame_done;
  bit        m_pressed;
  int        m_cand, m_run;
  logic [9:0] m_keypad;
  logic [3:0] m_code;
  logic       m_strobe;
  int         m_col;

  function automatic int dig_of(input int idx);
    if (idx / 3 < 3) return (idx / 3) * 3 + (idx % 3) + 1;
    if (idx == 10) return 0;
    return -1;
  endfunction

  function automatic bit [11:0] colmask(input int c);
    bit [11:0] m = '0;
    for (int r = 0; r < 4; r++) m[r*3+c] = 1'b1;
    return m;
  endfunction

  task automatic apply_frame(input bit [11:0] s);
    int k = -1;
    bit is_none, is_digit;
    if ($countones(s) == 1)
      for (int i = 0; i < 12; i++) if (s[i]) k = dig_of(i);
    is_none  = (s == 0);
    is_digit = ($countones(s) == 1) && (k >= 0);
    if (!m_pressed) begin
      if (is_digit && (m_run == 0 || k == m_cand)) begin
        if (m_run == 0) m_cand = k;
        m_run++;
      end else begin
        m_run = 0;
      end
      if (m_run == DEB) begin
        m_pressed = 1;
        m_run     = 0;
        m_keypad  = 10'd1 << m_cand;
        m_code    = 4'(m_cand);
        m_strobe  = 1'b1;
      end
    end else begin
      if (is_none) m_run++;
      else m_run = 0;
      if (m_run == DEB) begin
        m_pressed = 0;
        m_run     = 0;
        m_keypad  = '0;
      end
    end
  endtask

  always @(posedge clock) begin
    if (!resetn) begin
      n = 0; fe_edge = -1; frame_acc = '0; frame_done = '0;
      m_pressed = 0; m_cand = 0; m_run = 0;
      m_keypad = '0; m_code = '0; m_strobe = 1'b0; m_col = 0;
    end else begin
      n++;
      ring[n % 4] = held;
      m_strobe = 1'b0;
      if (n == fe_edge) apply_frame(frame_done);
      // Column c is sampled at the end of its slot, seeing rows two edges earlier
      if (n % S == 0) begin
        int c;
        bit [11:0] part;
        c = (n / S - 1) % 3;
        part = ring[(n - 2) % 4] & colmask(c);
        if (c == 0) frame_acc = part;
        else frame_acc = frame_acc | part;
        if (c == 2) begin
          frame_done = frame_acc;
          fe_edge    = n + 2;
        end
      end
      m_col = (n / S) % 3;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clock) begin
    #1;
    if (!resetn) begin
      chk("rst_cols", 32'(cols_n), 32'h6);
      chk("rst_keypad", 32'(keypad), 32'h0);
      chk("rst_code", 32'(key_code), 32'h0);
      chk("rst_strobe", 32'(key_strobe), 32'h0);
    end else begin
      chk("cols_n", 32'(cols_n), 32'(~(3'b001 << m_col) & 3'b111));
      chk("keypad", 32'(keypad), 32'(m_keypad));
      chk("key_code", 32'(key_code), 32'(m_code));
      chk("key_strobe", 32'(key_strobe), 32'(m_strobe));
      chk("onehot0", 32'($onehot0(keypad)), 32'h1);
    end
    if (key_strobe) strobe_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic clks(input int k);
    repeat (k) @(negedge clock);
  endtask

  task automatic wait_keypad(input int budget, output int cycles);
    cycles = 0;
    while (keypad == '0 && cycles < budget) begin
      @(negedge clock);
      cycles++;
    end
    if (keypad == '0) begin
      n_chk++; n_fail++;
      $display("FAIL wait_keypad: keypad still 0 after %0d clocks", budget);
    end
  endtask

  initial begin
    int lat;
    #1 resetn = 1'b0;
    clks(4);
    resetn = 1'b1;

    // Idle scanning, no keys
    clks(40);
    chk("idle_keypad", 32'(keypad), 32'h0);
    chk("idle_strobes", 32'(strobe_cnt), 0);

    // Key 5 (row1/col1)
    strobe_cnt = 0;
    held = 12'b1 << 4;
    wait_keypad(60, lat);
    chk("k5_latency_ok", 32'(lat <= 51), 1);
    clks(60 - lat);
    chk("k5_keypad", 32'(keypad), 32'h020);
    chk("k5_code", 32'(key_code), 32'h5);
    chk("k5_strobes", 32'(strobe_cnt), 1);
    held = '0;
    clks(50);
    chk("k5_rel_keypad", 32'(keypad), 32'h0);
    chk("k5_rel_code", 32'(key_code), 32'h5);

    // Key 0 bouncing, then stable
    strobe_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      held = (i % 2 == 0) ? (12'b1 << 10) : 12'b0;
      clks(5);
    end
    held = 12'b1 << 10;
    clks(60);
    chk("k0_keypad", 32'(keypad), 32'h001);
    chk("k0_strobes", 32'(strobe_cnt), 1);
    held = '0;
    clks(50);

    // Two digits together, then '*' alone: both rejected
    strobe_cnt = 0;
    held = (12'b1 << 0) | (12'b1 << 8);
    clks(60);
    chk("k19_keypad", 32'(keypad), 32'h0);
    held = '0;
    clks(40);
    held = 12'b1 << 9;
    clks(60);
    chk("star_keypad", 32'(keypad), 32'h0);
    chk("reject_strobes", 32'(strobe_cnt), 0);
    held = '0;
    clks(40);

    // 7, add 3, drop 7: output stays 7 until full release
    strobe_cnt = 0;
    held = 12'b1 << 6;
    clks(60);
    chk("k7_keypad", 32'(keypad), 32'h080);
    held = held | (12'b1 << 2);
    clks(30);
    held = 12'b1 << 2;
    clks(40);
    chk("k7_3_keypad", 32'(keypad), 32'h080);
    chk("k7_3_strobes", 32'(strobe_cnt), 1);
    held = '0;
    clks(50);
    chk("k7_rel_keypad", 32'(keypad), 32'h0);
    held = 12'b1 << 2;
    clks(60);
    chk("k3_keypad", 32'(keypad), 32'h008);
    chk("k3_strobes", 32'(strobe_cnt), 2);
    held = '0;
    clks(50);

    // Reset while key 2 is pressed
    held = 12'b1 << 1;
    clks(60);
    chk("k2_keypad", 32'(keypad), 32'h004);
    resetn = 1'b0;
    #1;
    chk("k2_rst_keypad", 32'(keypad), 32'h0);
    chk("k2_rst_code", 32'(key_code), 32'h0);
    clks(5);
    strobe_cnt = 0;
    resetn = 1'b1;
    wait_keypad(60, lat);
    clks(20);
    chk("k2_again_keypad", 32'(keypad), 32'h004);
    chk("k2_again_strobes", 32'(strobe_cnt), 1);
    held = '0;
    clks(50);

    // Random key activity against the model
    for (int it = 0; it < 250; it++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind <= 5) held = 12'b1 << $urandom_range(0, 11);
      else if (kind == 6) held = '0;
      else if (kind <= 8) held = (12'b1 << $urandom_range(0, 11)) | (12'b1 << $urandom_range(0, 11));
      else begin
        int idx;
        idx = $urandom_range(0, 11);
        for (int b = 0; b < 6; b++) begin
          held = (b % 2 == 0) ? (12'b1 << idx) : 12'b0;
          clks($urandom_range(1, 7));
        end
      end
      clks($urandom_range(1, 50));
      if ($urandom_range(0, 39) == 0) begin
        resetn = 1'b0;
        clks($urandom_range(1, 4));
        resetn = 1'b1;
      end
    end
    held = '0;
    clks(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
